// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-register definitions: handshake state and default stage field widths.
// Every stage boundary sizes its payload from these so IF/ID .. MEM/WB stay consistent.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int PIPE_CTRL_W_DEF = 4;
  localparam int PIPE_DATA_W_DEF = 32;
  localparam int PIPE_ADDR_W_DEF = 32;
  localparam int PIPE_RD_W_DEF   = 5;
  localparam int PIPE_WIDTH_DEF  = PIPE_CTRL_W_DEF + PIPE_DATA_W_DEF
                                 + PIPE_ADDR_W_DEF + PIPE_RD_W_DEF;

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    case (st)
      ST_FULL: occ_of = 2'd1;
      ST_SKID: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with one-entry skid buffer, flush and ctrl-field bubble masking.
// Latency 1 cycle, 1/cycle throughput; back-pressure parks one entry in skid, in_ready is a flop.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH       = PIPE_WIDTH_DEF,
  parameter int CTRL_W      = PIPE_CTRL_W_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_e            state_q, state_d;
  logic [WIDTH-1:0]       main_q, main_d;
  logic [WIDTH-1:0]       skid_q, skid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [WIDTH-1:0]       ctrl_mask;
  logic                   accept;
  logic                   emit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    assign ctrl_mask[i] = (i < CTRL_W) ? 1'b1 : 1'b0;
  end

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (out_valid_q && !out_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end

    // Flush squashes both sides of this cycle's handshakes; data regs are left stale.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (emit && accept) begin
            main_d = in_data;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_SKID;
          end
        end
        ST_SKID: begin
          if (emit) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d  = (state_d != ST_SKID);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q & ~(ctrl_mask & {WIDTH{~out_valid_q}});
  assign occupancy = occ_of(state_q);
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model, directed scenarios then random traffic.
module tb_pipe_skid_reg;

  localparam int W = 73;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occupancy;
  logic [2:0]   s_stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: ordered list of held payloads plus the value the main slot last held.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_main;
  int           m_stall16;
  int           m_stall3;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.STALL_CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc, emt;
    acc = in_valid && (mq.size() < 2);
    emt = (mq.size() > 0) && out_ready;
    if (rst) begin
      mq.delete();
      m_main    = '0;
      m_stall16 = 0;
      m_stall3  = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && !out_ready) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall3 < 7) m_stall3++;
      end
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) m_main = mq[0];
    end
  endtask

  task automatic compare_model();
    logic [W-1:0] exp_data;
    logic         exp_vld;
    exp_vld  = (mq.size() > 0);
    exp_data = exp_vld ? m_main : {m_main[W-1:4], 4'h0};
    check("out_valid", W'(out_valid), W'(exp_vld));
    check("out_data", out_data, exp_data);
    check("in_ready", W'(in_ready), W'(mq.size() < 2));
    check("occupancy", W'(occupancy), W'(mq.size()));
    check("stall_cnt", W'(stall_cnt), W'(m_stall16));
    check("s_out_valid", W'(s_out_valid), W'(exp_vld));
    check("s_out_data", s_out_data, exp_data);
    check("s_in_ready", W'(s_in_ready), W'(mq.size() < 2));
    check("s_occupancy", W'(s_occupancy), W'(mq.size()));
    check("s_stall_cnt", W'(s_stall_cnt), W'(m_stall3));
  endtask

  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] pay;

  initial begin
    ones = '1;
    m_main = '0; m_stall16 = 0; m_stall3 = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset while upstream is offering all-ones
    cycle(1, 0, 1, ones, 0);
    check("rst out_valid", W'(out_valid), '0);
    check("rst out_data", out_data, '0);
    check("rst in_ready", W'(in_ready), W'(1));
    check("rst occupancy", W'(occupancy), '0);
    check("rst stall_cnt", W'(stall_cnt), '0);

    // Streaming 1..8 with out_ready high
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 0, 1, W'(k), 1);
      check("stream data", out_data, W'(k));
      check("stream occ", W'(occupancy), W'(1));
    end
    cycle(0, 0, 0, '0, 1);
    check("stream drained", W'(out_valid), '0);

    // Back-pressure into skid, then release
    cycle(0, 0, 1, W'(4'hA), 0);
    cycle(0, 0, 1, W'(4'hB), 0);
    check("bp occ", W'(occupancy), W'(2));
    check("bp in_ready", W'(in_ready), '0);
    check("bp stall1", W'(stall_cnt), W'(1));
    for (int k = 2; k <= 4; k++) begin
      cycle(0, 0, 1, W'(4'hE), 0);
      check("bp stall", W'(stall_cnt), W'(k));
    end
    check("bp head", out_data, W'(4'hA));
    cycle(0, 0, 0, '0, 1);
    check("bp second", out_data, W'(4'hB));
    check("bp occ1", W'(occupancy), W'(1));
    cycle(0, 0, 0, '0, 1);
    check("bp empty", W'(out_valid), '0);

    // Flush while SKID, with an offer in the same cycle
    cycle(0, 0, 1, W'(4'hA), 0);
    cycle(0, 0, 1, W'(4'hB), 0);
    cycle(0, 1, 1, W'(4'hC), 0);
    check("flush valid", W'(out_valid), '0);
    check("flush occ", W'(occupancy), '0);
    check("flush ctrl", W'(out_data[3:0]), '0);
    check("flush in_ready", W'(in_ready), W'(1));
    cycle(0, 0, 0, '0, 1);
    check("flush no C", W'(out_valid), '0);

    // Ctrl masking on drain
    pay = {69'h1_2345_6789_ABCD_EF01, 4'hF};
    cycle(0, 0, 1, pay, 1);
    check("mask live", out_data, pay);
    cycle(0, 0, 0, '0, 1);
    check("mask valid", W'(out_valid), '0);
    check("mask ctrl", W'(out_data[3:0]), '0);
    check("mask upper", W'(out_data[W-1:4]), W'(pay[W-1:4]));

    // Saturation of the 3-bit counter, then rst with flush
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 1, W'(5), 0);
    for (int k = 0; k < 10; k++) cycle(0, 0, 0, '0, 0);
    check("sat s_stall", W'(s_stall_cnt), W'(7));
    check("sat stall16", W'(stall_cnt), W'(10));
    cycle(1, 1, 0, '0, 0);
    check("rstflush s_stall", W'(s_stall_cnt), '0);
    check("rstflush stall16", W'(stall_cnt), '0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), W'({$urandom, $urandom, $urandom}),
            ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
